// File: rtl/reset_release_monitor.sv
// Per-channel reset-release timing monitor: checks that each channel's reset
// deasserts within a legal cycle window after its power-good rising edge.
module reset_release_monitor #(
  parameter int N_CH    = 4,
  parameter int MIN_CYC = 1,
  parameter int MAX_CYC = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] power_up,
  input  logic [N_CH-1:0] ch_rst,
  input  logic            err_clr,
  input  logic [4:0]      lat_sel,
  output logic [N_CH-1:0] pass_pulse,
  output logic [N_CH-1:0] err_early,
  output logic [N_CH-1:0] err_timeout,
  output logic [N_CH-1:0] err_glitch,
  output logic            any_err,
  output logic [7:0]      lat_out,
  output logic [7:0]      fail_cnt
);

  if (N_CH < 1 || N_CH > 32 || MIN_CYC < 1 || MIN_CYC > MAX_CYC || MAX_CYC > 255) begin : g_bad_params
    $error("reset_release_monitor: need 1<=N_CH<=32 and 1<=MIN_CYC<=MAX_CYC<=255");
  end

  localparam logic [7:0] MIN_D = 8'(MIN_CYC);
  localparam logic [7:0] MAX_D = 8'(MAX_CYC);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_FAIL} state_t;

  logic [N_CH-1:0] prev_reg;
  logic [N_CH-1:0] pass_reg, early_reg, timeout_reg, glitch_reg;
  logic [N_CH-1:0] pass_set, early_set, timeout_set, glitch_set, fail_set;
  logic [N_CH-1:0] early_next, timeout_next, glitch_next;
  logic            any_err_reg;
  logic [7:0]      fail_cnt_reg;
  logic [5:0]      new_fails;
  logic [8:0]      fail_sum;
  logic [7:0]      lat_vec [N_CH];

  genvar gi;
  for (gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [7:0] lat_reg, lat_next;
    logic [7:0] d;
    logic       pass_evt, early_evt, timeout_evt, glitch_evt;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= S_IDLE;
        cnt_reg   <= 8'd0;
        lat_reg   <= 8'd0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        lat_reg   <= lat_next;
      end
    end

    // d is the index of the current sample counted from the power-up edge.
    always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      lat_next    = lat_reg;
      pass_evt    = 1'b0;
      early_evt   = 1'b0;
      timeout_evt = 1'b0;
      glitch_evt  = 1'b0;
      d           = cnt_reg + 8'd1;
      case (state_reg)
        S_IDLE: begin
          if (power_up[gi] && !prev_reg[gi]) begin
            state_next = S_WAIT;
            cnt_next   = 8'd0;
          end
        end
        S_WAIT: begin
          if (!power_up[gi]) begin
            state_next = S_IDLE;
          end else if (!ch_rst[gi]) begin
            if (d < MIN_D) begin
              early_evt  = 1'b1;
              state_next = S_FAIL;
            end else begin
              pass_evt   = 1'b1;
              lat_next   = d;
              state_next = S_DONE;
            end
          end else if (d == MAX_D) begin
            timeout_evt = 1'b1;
            state_next  = S_FAIL;
          end else begin
            cnt_next = d;
          end
        end
        S_DONE: begin
          if (!power_up[gi]) begin
            state_next = S_IDLE;
          end else if (ch_rst[gi]) begin
            glitch_evt = 1'b1;
            state_next = S_FAIL;
          end
        end
        S_FAIL: begin
          if (!power_up[gi]) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end

    assign pass_set[gi]    = pass_evt;
    assign early_set[gi]   = early_evt;
    assign timeout_set[gi] = timeout_evt;
    assign glitch_set[gi]  = glitch_evt;
    assign lat_vec[gi]     = lat_reg;
  end

  assign fail_set = early_set | timeout_set | glitch_set;

  // A flag set in the same cycle as err_clr survives the clear.
  always_comb begin
    early_next   = early_set   | (early_reg   & ~{N_CH{err_clr}});
    timeout_next = timeout_set | (timeout_reg & ~{N_CH{err_clr}});
    glitch_next  = glitch_set  | (glitch_reg  & ~{N_CH{err_clr}});
    new_fails    = 6'd0;
    for (int i = 0; i < N_CH; i++) new_fails = new_fails + 6'(fail_set[i]);
    fail_sum = {1'b0, fail_cnt_reg} + {3'b000, new_fails};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg     <= '0;
      pass_reg     <= '0;
      early_reg    <= '0;
      timeout_reg  <= '0;
      glitch_reg   <= '0;
      any_err_reg  <= 1'b0;
      fail_cnt_reg <= 8'd0;
    end else begin
      prev_reg     <= power_up;
      pass_reg     <= pass_set;
      early_reg    <= early_next;
      timeout_reg  <= timeout_next;
      glitch_reg   <= glitch_next;
      any_err_reg  <= |{early_next, timeout_next, glitch_next};
      fail_cnt_reg <= (fail_sum > 9'd255) ? 8'd255 : fail_sum[7:0];
    end
  end

  always_comb begin
    lat_out = 8'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (lat_sel == 5'(i)) lat_out = lat_vec[i];
    end
  end

  assign pass_pulse  = pass_reg;
  assign err_early   = early_reg;
  assign err_timeout = timeout_reg;
  assign err_glitch  = glitch_reg;
  assign any_err     = any_err_reg;
  assign fail_cnt    = fail_cnt_reg;

endmodule

// File: tb/tb_reset_release_monitor.sv
// Directed bench for reset_release_monitor: default window 1..5 plus a
// second instance with window 3..5 for the early/glitch cases.
module tb_reset_release_monitor;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pu = '0, crst = '0, pu3 = '0, crst3 = '0;
  logic       err_clr = 1'b0;
  logic [4:0] lat_sel = '0;
  logic [3:0] pass_pulse, err_early, err_timeout, err_glitch;
  logic [3:0] pass3, early3, timeout3, glitch3;
  logic       any_err, any_err3;
  logic [7:0] lat_out, fail_cnt, lat_out3, fail_cnt3;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_release_monitor #(.N_CH(4), .MIN_CYC(1), .MAX_CYC(5)) dut (
    .clk(clk), .reset(reset), .power_up(pu), .ch_rst(crst), .err_clr(err_clr),
    .lat_sel(lat_sel), .pass_pulse(pass_pulse), .err_early(err_early),
    .err_timeout(err_timeout), .err_glitch(err_glitch), .any_err(any_err),
    .lat_out(lat_out), .fail_cnt(fail_cnt));

  reset_release_monitor #(.N_CH(4), .MIN_CYC(3), .MAX_CYC(5)) dut3 (
    .clk(clk), .reset(reset), .power_up(pu3), .ch_rst(crst3), .err_clr(err_clr),
    .lat_sel(lat_sel), .pass_pulse(pass3), .err_early(early3),
    .err_timeout(timeout3), .err_glitch(glitch3), .any_err(any_err3),
    .lat_out(lat_out3), .fail_cnt(fail_cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; pu = '0; crst = '0; pu3 = '0; crst3 = '0; err_clr = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; lat_sel = 5'd0;
    tick(); tick();
    checks++; if ({pass_pulse, err_early, err_timeout, err_glitch} !== 16'h0) begin errors++; $display("FAIL reset_vec: got %h expected 0000", {pass_pulse, err_early, err_timeout, err_glitch}); end
    checks++; if ({any_err, fail_cnt, lat_out} !== 17'h0) begin errors++; $display("FAIL reset_misc: got %h expected 0", {any_err, fail_cnt, lat_out}); end
    checks++; if ({pass3, early3, timeout3, glitch3, any_err3, fail_cnt3} !== 25'h0) begin errors++; $display("FAIL reset_dut3: got %h expected 0", {pass3, early3, timeout3, glitch3, any_err3, fail_cnt3}); end
    reset = 1'b0;
  endtask

  task automatic test_pass();
    do_reset();
    pu = 4'b0001; crst = 4'b0001;
    tick();                // T0
    tick(); tick();        // d=1,2
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL pass_early_look: got %b expected 0000", pass_pulse); end
    crst = 4'b0000;
    tick();                // d=3 release
    lat_sel = 5'd0; #1;
    checks++; if (pass_pulse !== 4'b0001) begin errors++; $display("FAIL pass_ch0: got %b expected 0001", pass_pulse); end
    checks++; if (lat_out !== 8'd3) begin errors++; $display("FAIL lat_ch0: got %0d expected 3", lat_out); end
    checks++; if ({any_err, err_early, err_timeout, err_glitch} !== 13'h0) begin errors++; $display("FAIL pass_noflag: got %h expected 0", {any_err, err_early, err_timeout, err_glitch}); end
    lat_sel = 5'd7; #1;
    checks++; if (lat_out !== 8'd0) begin errors++; $display("FAIL lat_oob: got %0d expected 0", lat_out); end
    tick();
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL pass_one_cycle: got %b expected 0000", pass_pulse); end
  endtask

  task automatic test_release_at_edge();
    do_reset();
    pu = 4'b1000; crst = 4'b0000;
    tick();                // T0, low reset ignored here
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL edge_ignore: got %b expected 0000", pass_pulse); end
    tick();                // d=1
    lat_sel = 5'd3; #1;
    checks++; if (pass_pulse !== 4'b1000) begin errors++; $display("FAIL edge_pass_d1: got %b expected 1000", pass_pulse); end
    checks++; if (lat_out !== 8'd1) begin errors++; $display("FAIL edge_lat: got %0d expected 1", lat_out); end
  endtask

  task automatic test_timeout();
    do_reset();
    pu = 4'b0010; crst = 4'b0010;
    tick();
    repeat (4) tick();
    checks++; if (err_timeout !== 4'b0000) begin errors++; $display("FAIL timeout_d4: got %b expected 0000", err_timeout); end
    tick();                // d=5
    checks++; if (err_timeout !== 4'b0010) begin errors++; $display("FAIL timeout_ch1: got %b expected 0010", err_timeout); end
    checks++; if (any_err !== 1'b1) begin errors++; $display("FAIL timeout_any: got %b expected 1", any_err); end
    checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL timeout_cnt: got %0d expected 1", fail_cnt); end
    pu = 4'b0000; tick();
    checks++; if (err_timeout !== 4'b0010) begin errors++; $display("FAIL timeout_sticky: got %b expected 0010", err_timeout); end
    pu = 4'b0010; crst = 4'b0010;
    tick();
    repeat (4) tick();
    crst = 4'b0000;
    tick();                // release exactly at d=5
    lat_sel = 5'd1; #1;
    checks++; if (pass_pulse !== 4'b0010) begin errors++; $display("FAIL max_pass: got %b expected 0010", pass_pulse); end
    checks++; if (lat_out !== 8'd5) begin errors++; $display("FAIL max_lat: got %0d expected 5", lat_out); end
    checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL max_cnt: got %0d expected 1", fail_cnt); end
  endtask

  task automatic test_early_glitch();
    do_reset();
    pu3 = 4'b0001; crst3 = 4'b0001;
    tick(); tick();        // T0, d=1
    crst3 = 4'b0000;
    tick();                // d=2 < MIN 3
    checks++; if (early3 !== 4'b0001) begin errors++; $display("FAIL early_ch0: got %b expected 0001", early3); end
    checks++; if (pass3 !== 4'b0000) begin errors++; $display("FAIL early_nopass: got %b expected 0000", pass3); end
    checks++; if (fail_cnt3 !== 8'd1) begin errors++; $display("FAIL early_cnt: got %0d expected 1", fail_cnt3); end
    pu3 = 4'b0101; crst3 = 4'b0100;
    tick();                // T0 for ch2
    tick(); tick();        // d=1,2
    crst3 = 4'b0000;
    tick();                // d=3 == MIN
    lat_sel = 5'd2; #1;
    checks++; if (pass3 !== 4'b0100) begin errors++; $display("FAIL min_pass: got %b expected 0100", pass3); end
    checks++; if (lat_out3 !== 8'd3) begin errors++; $display("FAIL min_lat: got %0d expected 3", lat_out3); end
    tick();
    crst3 = 4'b0100;
    tick();
    checks++; if (glitch3 !== 4'b0100) begin errors++; $display("FAIL glitch_ch2: got %b expected 0100", glitch3); end
    checks++; if (fail_cnt3 !== 8'd2) begin errors++; $display("FAIL glitch_cnt: got %0d expected 2", fail_cnt3); end
    checks++; if (early3 !== 4'b0001) begin errors++; $display("FAIL early_kept: got %b expected 0001", early3); end
  endtask

  task automatic test_abort();
    do_reset();
    pu = 4'b0100; crst = 4'b0100;
    tick(); tick();        // T0, d=1
    pu = 4'b0000; crst = 4'b0000;
    tick();                // d=2: drop wins over release
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL abort_nopass: got %b expected 0000", pass_pulse); end
    repeat (6) tick();
    checks++; if ({any_err, err_early, err_timeout, err_glitch, fail_cnt} !== 21'h0) begin errors++; $display("FAIL abort_noflag: got %h expected 0", {any_err, err_early, err_timeout, err_glitch, fail_cnt}); end
    pu = 4'b0100; crst = 4'b0100;
    tick(); tick();
    crst = 4'b0000;
    tick();                // d=2
    lat_sel = 5'd2; #1;
    checks++; if (pass_pulse !== 4'b0100) begin errors++; $display("FAIL abort_rerun: got %b expected 0100", pass_pulse); end
    checks++; if (lat_out !== 8'd2) begin errors++; $display("FAIL abort_lat: got %0d expected 2", lat_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pu = 4'b1111; crst = 4'b1111;
    tick();
    repeat (4) tick();
    checks++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL multi_pre: got %0d expected 0", fail_cnt); end
    tick();
    checks++; if (err_timeout !== 4'b1111) begin errors++; $display("FAIL multi_flags: got %b expected 1111", err_timeout); end
    checks++; if (fail_cnt !== 8'd4) begin errors++; $display("FAIL multi_cnt: got %0d expected 4", fail_cnt); end
    pu = 4'b0111; tick();
    pu = 4'b1111; tick();  // fresh T0 on ch3
    repeat (4) tick();
    err_clr = 1'b1;
    tick();                // ch3 timeout coincides with clear
    err_clr = 1'b0;
    checks++; if (err_timeout !== 4'b1000) begin errors++; $display("FAIL clr_race: got %b expected 1000", err_timeout); end
    checks++; if (fail_cnt !== 8'd5) begin errors++; $display("FAIL clr_cnt: got %0d expected 5", fail_cnt); end
    checks++; if (any_err !== 1'b1) begin errors++; $display("FAIL clr_any: got %b expected 1", any_err); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if ({any_err, err_timeout} !== 5'b0) begin errors++; $display("FAIL clr_all: got %b expected 00000", {any_err, err_timeout}); end
    checks++; if (fail_cnt !== 8'd5) begin errors++; $display("FAIL clr_keeps_cnt: got %0d expected 5", fail_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 66; r++) begin
      pu = 4'b0000; crst = 4'b1111; tick();
      pu = (r == 63) ? 4'b0011 : 4'b1111; tick();
      repeat (5) tick();
      if (r == 63) begin
        checks++; if (fail_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", fail_cnt); end
      end
      if (r == 64) begin
        checks++; if (fail_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", fail_cnt); end
      end
    end
    checks++; if (fail_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", fail_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    pu = 4'b0000; tick();
    pu = 4'b0001; crst = 4'b0001;
    tick(); tick();        // T0, d=1
    reset = 1'b1; crst = 4'b0000;
    tick();
    lat_sel = 5'd0; #1;
    checks++; if ({pass_pulse, err_timeout, any_err} !== 9'h0) begin errors++; $display("FAIL rst_mid_vec: got %b expected 0", {pass_pulse, err_timeout, any_err}); end
    checks++; if ({fail_cnt, lat_out} !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt: got %h expected 0000", {fail_cnt, lat_out}); end
    tick();
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL rst_hold: got %b expected 0000", pass_pulse); end
    reset = 1'b0; crst = 4'b0001;
    tick();                // first post-reset sample is the edge
    tick();                // d=1
    checks++; if (pass_pulse !== 4'b0000) begin errors++; $display("FAIL rst_post_wait: got %b expected 0000", pass_pulse); end
    crst = 4'b0000;
    tick();                // d=2
    checks++; if (pass_pulse !== 4'b0001) begin errors++; $display("FAIL rst_post_pass: got %b expected 0001", pass_pulse); end
    checks++; if (lat_out !== 8'd2) begin errors++; $display("FAIL rst_post_lat: got %0d expected 2", lat_out); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_release_at_edge();
    test_timeout();
    test_early_glitch();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reset_release_monitor.md
RESET_RELEASE_MONITOR -- requirements
Module: reset_release_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent monitored channels (1..32).
REQ-002 SHALL have parameter MIN_CYC, default 1, earliest legal reset-release cycle after power-up edge.
REQ-003 SHALL have parameter MAX_CYC, default 5, latest legal reset-release cycle after power-up edge; elaboration SHALL fail unless 1 <= MIN_CYC <= MAX_CYC <= 255.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high block reset.
REQ-006 SHALL have port power_up  input  N_CH  per-channel power-good level.
REQ-007 SHALL have port ch_rst  input  N_CH  per-channel monitored reset, 1 = asserted.
REQ-008 SHALL have port err_clr  input  1  one-cycle pulse clearing all sticky error flags.
REQ-009 SHALL have port lat_sel  input  5  channel index for latency readback.
REQ-010 SHALL have port pass_pulse  output  N_CH  one-cycle pulse per channel on legal release.
REQ-011 SHALL have port err_early / err_timeout / err_glitch  output  N_CH each  sticky per-channel violation flags.
REQ-012 SHALL have port any_err  output  1  OR of all sticky flags.
REQ-013 SHALL have port lat_out  output  8  last passing release latency of channel lat_sel (0 if lat_sel >= N_CH).
REQ-014 SHALL have port fail_cnt  output  8  saturating count of error events, all channels.

Function
REQ-015 Each channel SHALL run an independent FSM: IDLE, WAIT, DONE, FAIL.
REQ-016 Power-up edge SHALL be a sample of power_up[i]=1 whose previous sample was 0; previous sample SHALL read as 0 on the first cycle after reset.
REQ-017 IDLE -> WAIT on power-up edge sample T0; 8-bit cycle counter loaded with 0, counts samples after T0 (d = 1 at T0+1).
REQ-018 In WAIT, ch_rst[i]=0 at d with d < MIN_CYC: set err_early[i], go FAIL.
REQ-019 In WAIT, ch_rst[i]=0 at d with MIN_CYC <= d <= MAX_CYC: pass_pulse[i]=1 for the following cycle, store d as channel latency, go DONE.
REQ-020 In WAIT, ch_rst[i]=1 at d = MAX_CYC: set err_timeout[i], go FAIL; release exactly at MAX_CYC SHALL pass.
REQ-021 In WAIT, power_up[i]=0 sampled: abort to IDLE, no verdict, no flag; abort SHALL win over a same-sample release.
REQ-022 ch_rst[i] value at T0 SHALL be ignored (already-low reset at edge is judged from d = 1).
REQ-023 In DONE, ch_rst[i]=1 while power_up[i]=1: set err_glitch[i], go FAIL.
REQ-024 DONE or FAIL -> IDLE when power_up[i]=0 sampled; sticky flags SHALL NOT clear on this.
REQ-025 All outputs registered; verdicts and flags visible one cycle after the deciding sample.
REQ-026 err_clr SHALL clear all sticky flags next cycle; an error set in the same cycle SHALL win (flag stays 1).
REQ-027 fail_cnt SHALL add the number of channels newly entering FAIL each cycle, saturating at 255; err_clr SHALL NOT reset it.
REQ-028 Latency storage per channel SHALL be 8 bits; lat_out combinationally muxed from registered storage.

Reset
REQ-029 On reset sampled high: all FSMs IDLE, counters 0, stored latencies 0, pass_pulse 0, all err flags 0, any_err 0, fail_cnt 0, edge-history 0.
REQ-030 Reset mid-WAIT SHALL discard the in-flight check with no verdict; a power_up held high across reset release SHALL produce a new edge on the first post-reset sample.

Verification
REQ-031 Ch0: power_up 0->1 at T0, ch_rst low at T0+3 (MIN 1, MAX 5) -> pass_pulse[0] at T0+4, lat_out=3 with lat_sel=0, no flags.
REQ-032 Ch1: ch_rst held high through T0+5 -> err_timeout[1]=1 at T0+6, any_err=1, fail_cnt=1; release at exactly T0+5 in rerun -> pass, lat 5.
REQ-033 MIN_CYC=3: ch_rst low at T0+2 -> err_early=1; ch2 passes then ch_rst pulses high with power_up high -> err_glitch[2]=1.
REQ-034 power_up drops at T0+2 coincident with ch_rst release -> no pass, no flag, FSM IDLE; re-edge later starts fresh check.
REQ-035 Four channels timeout same cycle -> fail_cnt +4; err_clr coincident with new error on ch3 -> ch3 flag stays, others clear; fail_cnt at 254 plus 4 events -> 255.
REQ-036 reset asserted at T0+2 during WAIT, power_up held 1 -> no verdict; new check starts at first post-reset sample, all outputs 0 during reset.
